// File: rtl/noise_gate.sv
// Purpose : noise gate for raw ADC samples; a peak envelope drives a 5-state gate with hold and gain ramps.
// Latency : 1 clk from sample_valid to out_valid; out_sample holds its value between strobes.
// Backpres: none; one sample is accepted on every sample_valid strobe, with no stall path.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset; also drops any sample in flight
//   sample_valid one-cycle strobe; a new sample is present
//   sample       signed input sample (two's complement, DATA_W bits)
//   thr_open     unsigned envelope level that opens the gate
//   thr_close    unsigned envelope level below which hold starts (clamped to thr_open)
//   out_sample   signed gated sample, (sample * gain) >>> 8
//   out_valid    strobe, one clk after sample_valid
//   gate_open    high while in ATTACK, OPEN or HOLD (registered, post-update state)

module noise_gate #(
    parameter int DATA_W       = 16,
    parameter int ENV_SHIFT    = 6,
    parameter int HOLD_SAMPLES = 2048,
    parameter int ATTACK_STEP  = 32,
    parameter int RELEASE_STEP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] thr_open,
    input  logic [DATA_W-1:0] thr_close,
    output logic [DATA_W-1:0] out_sample,
    output logic              out_valid,
    output logic              gate_open
);

    // ------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------
    localparam int GAIN_W = 9;                       // 0..256, 256 = unity
    localparam int PROD_W = DATA_W + GAIN_W + 1;     // signed product width
    localparam int HOLD_W = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;

    localparam logic [GAIN_W-1:0] GAIN_UNITY = 9'd256;
    localparam logic [GAIN_W-1:0] GAIN_ZERO  = 9'd0;
    localparam logic [GAIN_W:0]   ATK_INC    = 10'(ATTACK_STEP);
    localparam logic [GAIN_W:0]   UNITY_EXT  = 10'd256;
    localparam logic [GAIN_W-1:0] REL_DEC    = 9'(RELEASE_STEP);

    localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(HOLD_SAMPLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO  = '0;

    localparam logic [DATA_W-1:0] MOST_NEG   = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MAX_POS    = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] ENV_ONE    = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] ENV_ZERO   = '0;

    typedef enum logic [2:0] {
        ST_CLOSED  = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_OPEN    = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state;
    state_t              state_nxt;
    logic [GAIN_W-1:0]   gain;
    logic [GAIN_W-1:0]   gain_nxt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_nxt;
    logic [DATA_W-1:0]   env;
    logic                gate_open_nxt;

    // ------------------------------------------------------------------
    // Envelope follower
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] abs_val;
    logic [DATA_W-1:0] env_shr;
    logic [DATA_W-1:0] decay_amt;
    logic [DATA_W-1:0] decayed;
    logic [DATA_W-1:0] env_next;

    // |sample|; the most negative code has no positive twin, so it pins
    // to the largest positive value instead of wrapping back to itself.
    always_comb begin
        abs_val = sample;
        if (sample[DATA_W-1]) begin
            if (sample == MOST_NEG) begin
                abs_val = MAX_POS;
            end else begin
                abs_val = ENV_ZERO - sample;
            end
        end
    end

    // Decay by env >> ENV_SHIFT, but at least 1 so small envelopes
    // still reach zero instead of stalling once the shift underflows.
    always_comb begin
        env_shr   = env >> ENV_SHIFT;
        decay_amt = (env_shr == ENV_ZERO) ? ENV_ONE : env_shr;
        decayed   = (env != ENV_ZERO) ? (env - decay_amt) : ENV_ZERO;
        env_next  = (abs_val > decayed) ? abs_val : decayed;
    end

    // ------------------------------------------------------------------
    // Threshold compare (thresholds are live, not latched)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] eff_close;
    logic              above_open;
    logic              below_close;

    // A close level above the open level would make the gate chatter;
    // clamp it so hysteresis can only be zero or positive.
    assign eff_close   = (thr_close < thr_open) ? thr_close : thr_open;
    assign above_open  = (env_next >= thr_open);
    assign below_close = (env_next <  eff_close);

    // ------------------------------------------------------------------
    // Gain ramp arithmetic
    // ------------------------------------------------------------------
    logic [GAIN_W:0]   gain_up;
    logic              gain_up_full;
    logic [GAIN_W-1:0] gain_up_sat;
    logic              gain_dn_zero;
    logic [GAIN_W-1:0] gain_dn_sat;

    always_comb begin
        gain_up      = {1'b0, gain} + ATK_INC;
        gain_up_full = (gain_up >= UNITY_EXT);
        gain_up_sat  = gain_up_full ? GAIN_UNITY : gain_up[GAIN_W-1:0];
        gain_dn_zero = (gain <= REL_DEC);
        gain_dn_sat  = gain_dn_zero ? GAIN_ZERO : (gain - REL_DEC);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_CLOSED;
            gain     <= GAIN_ZERO;
            hold_cnt <= HOLD_ZERO;
        end else begin
            state    <= state_nxt;
            gain     <= gain_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic (only moves on a valid sample)
    // ------------------------------------------------------------------
    // Every transition into ATTACK or RELEASE applies that state's ramp
    // step in the same update, so the first ramped sample follows the
    // triggering one directly and a re-attack from RELEASE continues from
    // the current gain rather than jumping.
    always_comb begin
        state_nxt = state;
        gain_nxt  = gain;
        hold_nxt  = hold_cnt;
        if (sample_valid) begin
            case (state)
                ST_CLOSED: begin
                    gain_nxt = GAIN_ZERO;
                    if (above_open) begin
                        gain_nxt  = gain_up_sat;
                        state_nxt = gain_up_full ? ST_OPEN : ST_ATTACK;
                    end
                end
                ST_ATTACK: begin
                    // The attack always completes; the envelope cannot abort it.
                    gain_nxt = gain_up_sat;
                    if (gain_up_full) begin
                        state_nxt = ST_OPEN;
                    end
                end
                ST_OPEN: begin
                    gain_nxt = GAIN_UNITY;
                    if (below_close) begin
                        state_nxt = ST_HOLD;
                        hold_nxt  = HOLD_LOAD;
                    end
                end
                ST_HOLD: begin
                    gain_nxt = GAIN_UNITY;
                    if (above_open) begin
                        state_nxt = ST_OPEN;
                    end else if (hold_cnt == HOLD_ZERO) begin
                        gain_nxt  = gain_dn_sat;
                        state_nxt = gain_dn_zero ? ST_CLOSED : ST_RELEASE;
                    end else begin
                        hold_nxt = hold_cnt - HOLD_ONE;
                    end
                end
                ST_RELEASE: begin
                    if (above_open) begin
                        gain_nxt  = gain_up_sat;
                        state_nxt = gain_up_full ? ST_OPEN : ST_ATTACK;
                    end else begin
                        gain_nxt  = gain_dn_sat;
                        if (gain_dn_zero) begin
                            state_nxt = ST_CLOSED;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_CLOSED;
                    gain_nxt  = GAIN_ZERO;
                    hold_nxt  = HOLD_ZERO;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: output decode (of the post-update state, registered below)
    // ------------------------------------------------------------------
    always_comb begin
        gate_open_nxt = 1'b0;
        case (state_nxt)
            ST_ATTACK,
            ST_OPEN,
            ST_HOLD:  gate_open_nxt = 1'b1;
            default:  gate_open_nxt = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Gain multiply: uses the gain before this sample's update
    // ------------------------------------------------------------------
    logic signed [PROD_W-1:0] sample_ext;
    logic signed [PROD_W-1:0] gain_ext;
    logic signed [PROD_W-1:0] prod;
    logic [DATA_W-1:0]        scaled;
    logic                     unused_prod;

    assign sample_ext = PROD_W'($signed(sample));
    assign gain_ext   = $signed(PROD_W'(gain));
    assign prod       = sample_ext * gain_ext;
    // Dropping the low 8 bits of a two's complement value is the
    // arithmetic shift right by 8 (rounds toward -inf). Gain <= 256 means
    // the result always fits back into DATA_W bits.
    assign scaled      = prod[DATA_W+7:8];
    assign unused_prod = ^{prod[PROD_W-1:DATA_W+8], prod[7:0]};

    // ------------------------------------------------------------------
    // Envelope and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            env        <= ENV_ZERO;
            out_sample <= '0;
            out_valid  <= 1'b0;
            gate_open  <= 1'b0;
        end else begin
            out_valid <= sample_valid;
            gate_open <= gate_open_nxt;
            if (sample_valid) begin
                env        <= env_next;
                out_sample <= scaled;
            end
        end
    end

endmodule

// File: tb/tb_noise_gate.sv
// Purpose : scoreboard bench for noise_gate; stimulus pushes expected outputs, a monitor pops and compares.
// Latency : expects out_valid exactly one clk after each accepted strobe.
// Backpres: none; the DUT never stalls, the monitor checks every falling edge.

module tb_noise_gate;

    localparam int DW = 16;
    localparam int H  = 2048;

    logic          clk = 1'b0;
    logic          rst;
    logic          sample_valid;
    logic [DW-1:0] sample;
    logic [DW-1:0] thr_open;
    logic [DW-1:0] thr_close;
    logic [DW-1:0] out_sample;
    logic          out_valid;
    logic          gate_open;

    always #5 clk = ~clk;

    noise_gate #(
        .DATA_W       (DW),
        .ENV_SHIFT    (6),
        .HOLD_SAMPLES (H),
        .ATTACK_STEP  (32),
        .RELEASE_STEP (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample       (sample),
        .thr_open     (thr_open),
        .thr_close    (thr_close),
        .out_sample   (out_sample),
        .out_valid    (out_valid),
        .gate_open    (gate_open)
    );

    typedef struct packed {
        logic [DW-1:0] s;
        logic          g;
    } exp_t;

    exp_t          q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            mdl_env = 0;
    logic          vld_d = 1'b0;
    logic          rst_d = 1'b1;
    logic [DW-1:0] last_out = '0;
    logic          last_gate = 1'b0;

    // Envelope reference, used only to know how many samples the decay takes.
    function automatic int env_step(input int e, input logic [DW-1:0] s);
        int a;
        int k;
        int d;
        a = $signed(s);
        if (a < 0) a = -a;
        if (a > 32767) a = 32767;
        k = e >>> 6;
        if (k < 1) k = 1;
        d = (e > 0) ? e - k : 0;
        return (a > d) ? a : d;
    endfunction

    // Expected strobe timing and reset visibility, one clk behind the inputs.
    always @(posedge clk) begin
        vld_d <= rst ? 1'b0 : sample_valid;
        rst_d <= rst;
    end

    // Monitor: pops the scoreboard whenever the DUT presents an output.
    always @(negedge clk) begin
        exp_t e;
        if (rst_d) begin
            n_cmp++;
            if (out_sample !== '0 || out_valid !== 1'b0 || gate_open !== 1'b0) begin
                n_err++;
                $display("FAIL reset_state: got sample=%0d valid=%0b gate=%0b, want 0/0/0",
                         $signed(out_sample), out_valid, gate_open);
            end
            last_out  = '0;
            last_gate = 1'b0;
        end else begin
            n_cmp++;
            if (out_valid !== vld_d) begin
                n_err++;
                $display("FAIL valid_timing at %0t: got out_valid=%0b, want %0b", $time, out_valid, vld_d);
            end
            if (out_valid === 1'b1) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_output at %0t: got sample=%0d, want no output",
                             $time, $signed(out_sample));
                end else begin
                    e = q.pop_front();
                    if (out_sample !== e.s || gate_open !== e.g) begin
                        n_err++;
                        $display("FAIL out at %0t: got sample=%0d gate=%0b, want sample=%0d gate=%0b",
                                 $time, $signed(out_sample), gate_open, $signed(e.s), e.g);
                    end
                    last_out  = e.s;
                    last_gate = e.g;
                end
            end else begin
                n_cmp++;
                if (out_sample !== last_out || gate_open !== last_gate) begin
                    n_err++;
                    $display("FAIL idle_hold at %0t: got sample=%0d gate=%0b, want sample=%0d gate=%0b",
                             $time, $signed(out_sample), gate_open, $signed(last_out), last_gate);
                end
            end
        end
    end

    // Issue one strobe (entered and left at posedge+1), then gap idle cycles.
    task automatic send(input logic [DW-1:0] s, input logic [DW-1:0] es, input logic eg, input int gap);
        sample       = s;
        sample_valid = 1'b1;
        q.push_back({es, eg});
        mdl_env = env_step(mdl_env, s);
        @(posedge clk); #1;
        sample_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        sample_valid = 1'b0;
        mdl_env      = 0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    // Feed constant s (out = es, gate open) until the envelope falls below lim.
    task automatic decay_until(input logic [DW-1:0] s, input logic [DW-1:0] es, input int lim);
        int  guard;
        logic crossed;
        guard = 0;
        crossed = 1'b0;
        while (!crossed && guard < 5000) begin
            crossed = (env_step(mdl_env, s) < lim);
            send(s, es, 1'b1, 1);
            guard++;
        end
        if (!crossed) begin
            n_err++;
            $display("FAIL decay_bound: got no crossing after %0d samples, want crossing below %0d", guard, lim);
        end
    endtask

    // Watchdog
    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: got timeout, want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample       = '0;
        thr_open     = 16'd1000;
        thr_close    = 16'd500;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // ---- A: silence, attack with 5-cycle gaps, hold, release to CLOSED
        for (int i = 0; i < 10; i++) send(16'd0, 16'd0, 1'b0, 1);
        send(16'd8000, 16'd0, 1'b1, 5);
        for (int k = 1; k <= 7; k++) send(16'd8000, 16'(1000 * k), 1'b1, 5);
        send(16'd8000, 16'd8000, 1'b1, 5);
        send(16'd8000, 16'd8000, 1'b1, 1);
        decay_until(16'd100, 16'd100, 500);
        for (int i = 1; i <= H; i++) send(16'd100, 16'd100, (i < H), 1);
        for (int j = 1; j <= 63; j++) send(16'd100, 16'((100 * (256 - 4 * j)) / 256), 1'b0, 1);
        send(16'd100, 16'd0, 1'b0, 1);

        // ---- B: -32768 at gain 0, re-attack mid-release at gain 128, -32768 at unity
        do_reset();
        send(16'h8000, 16'd0, 1'b1, 1);
        for (int k = 1; k <= 7; k++) send(16'd8000, 16'(1000 * k), 1'b1, 1);
        send(16'd8000, 16'd8000, 1'b1, 1);
        decay_until(16'd100, 16'd100, 500);
        for (int i = 1; i <= H; i++) send(16'd100, 16'd100, (i < H), 1);
        for (int j = 1; j <= 31; j++) send(16'd100, 16'((100 * (256 - 4 * j)) / 256), 1'b0, 1);
        send(16'h8000, 16'hC000, 1'b1, 1);
        for (int k = 5; k <= 7; k++) send(16'd8000, 16'(1000 * k), 1'b1, 1);
        send(16'd8000, 16'd8000, 1'b1, 1);
        send(16'h8000, 16'h8000, 1'b1, 1);

        // ---- C: close threshold above open is clamped, then reset while OPEN
        do_reset();
        thr_close = 16'd2000;
        send(16'd8000, 16'd0, 1'b1, 1);
        for (int k = 1; k <= 7; k++) send(16'd8000, 16'(1000 * k), 1'b1, 1);
        send(16'd8000, 16'd8000, 1'b1, 1);
        decay_until(16'd1500, 16'd1500, 2000);
        for (int i = 0; i < H + 8; i++) send(16'd1500, 16'd1500, 1'b1, 1);

        // Reset coincident with a strobe: the sample must be dropped.
        sample       = 16'd8000;
        sample_valid = 1'b1;
        rst          = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        rst          = 1'b0;
        mdl_env      = 0;
        @(posedge clk); #1;
        send(16'd8000, 16'd0, 1'b1, 1);
        send(16'd8000, 16'd1000, 1'b1, 1);

        repeat (4) @(posedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
